// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks hour/min/sec edit fields from debounced
// button pulses, keeps shadow values, and strobes them to the timekeeper.
module clock_set_ctrl #(
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int BLINK_CYC   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       editing,
  output logic [1:0] field,
  output logic       blink
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [2:0] {
    RUN,
    EDIT_HOUR,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_t;

  state_t        state, state_nx;
  logic [4:0]    hour_nx;
  logic [5:0]    min_nx, sec_nx;
  logic [TW-1:0] idle_cnt, idle_nx;
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          blink_nx, load_nx, editing_nx;
  logic [1:0]    field_nx;
  logic          any_btn, step_up, step_dn, stepped, timed_out;
  logic          edit_nx, entering;

  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    if (up) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    else    return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic up);
    if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
  endfunction

  always_comb begin
    state_nx  = state;
    hour_nx   = set_hour;
    min_nx    = set_min;
    sec_nx    = set_sec;
    stepped   = 1'b0;
    any_btn   = btn_mode | btn_up | btn_down;
    step_up   = btn_up & ~btn_down & ~btn_mode;
    step_dn   = btn_down & ~btn_up & ~btn_mode;
    timed_out = ~any_btn && (idle_cnt == TO_LAST);

    case (state)
      RUN: begin
        if (btn_mode) begin
          // Out-of-range live values are sanitised so the shadow never holds one.
          hour_nx  = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
          min_nx   = (cur_min > 6'd59) ? 6'd0 : cur_min;
          sec_nx   = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
          state_nx = EDIT_HOUR;
        end
      end
      EDIT_HOUR: begin
        if (btn_mode) state_nx = EDIT_MIN;
        else if (step_up || step_dn) begin
          stepped = 1'b1;
          hour_nx = hour_step(set_hour, step_up);
        end else if (timed_out) state_nx = RUN;
      end
      EDIT_MIN: begin
        if (btn_mode) state_nx = EDIT_SEC;
        else if (step_up || step_dn) begin
          stepped = 1'b1;
          min_nx  = sixty_step(set_min, step_up);
        end else if (timed_out) state_nx = RUN;
      end
      EDIT_SEC: begin
        if (btn_mode) state_nx = COMMIT;
        else if (step_up || step_dn) begin
          stepped = 1'b1;
          sec_nx  = sixty_step(set_sec, step_up);
        end else if (timed_out) state_nx = RUN;
      end
      COMMIT:  state_nx = RUN;
      default: state_nx = RUN;
    endcase

    edit_nx  = (state_nx == EDIT_HOUR) || (state_nx == EDIT_MIN) || (state_nx == EDIT_SEC);
    entering = (state_nx != state);

    idle_nx = (!edit_nx || entering || any_btn) ? '0 : idle_cnt + TW'(1);

    // Blink restarts visible on field entry or a value change so the user sees the edit.
    if (!edit_nx || entering || stepped) begin
      blink_nx     = 1'b1;
      blink_cnt_nx = '0;
    end else if (blink_cnt == BL_LAST) begin
      blink_nx     = ~blink;
      blink_cnt_nx = '0;
    end else begin
      blink_nx     = blink;
      blink_cnt_nx = blink_cnt + BW'(1);
    end

    case (state_nx)
      EDIT_HOUR: field_nx = 2'd1;
      EDIT_MIN:  field_nx = 2'd2;
      EDIT_SEC:  field_nx = 2'd3;
      default:   field_nx = 2'd0;
    endcase
    editing_nx = (field_nx != 2'd0);
    load_nx    = (state_nx == COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b1;
      load      <= 1'b0;
      field     <= 2'd0;
      editing   <= 1'b0;
    end else begin
      state     <= state_nx;
      set_hour  <= hour_nx;
      set_min   <= min_nx;
      set_sec   <= sec_nx;
      idle_cnt  <= idle_nx;
      blink_cnt <= blink_cnt_nx;
      blink     <= blink_nx;
      load      <= load_nx;
      field     <= field_nx;
      editing   <= editing_nx;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short timeout and blink periods.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load, editing, blink;
  logic [1:0] field;

  int vectors = 0;
  int miscompares = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TIMEOUT_CYC(20), .BLINK_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .load(load), .editing(editing), .field(field), .blink(blink)
  );

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic m, input logic u, input logic d);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    tick(1);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, "_hour"}, 32'(set_hour), 32'(h));
    checkOutput({tag, "_min"},  32'(set_min),  32'(m));
    checkOutput({tag, "_sec"},  32'(set_sec),  32'(s));
  endtask

  initial begin
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    #12;
    checkOutput("rst_field", 32'(field), 0);
    checkOutput("rst_editing", 32'(editing), 0);
    checkOutput("rst_load", 32'(load), 0);
    checkOutput("rst_blink", 32'(blink), 1);
    checkTime("rst", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    checkOutput("idle_field", 32'(field), 0);

    // Full sequence 12:34:56 -> 14:33:57
    applyStimulus(1, 0, 0);
    cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    checkOutput("seq_field_h", 32'(field), 1);
    checkOutput("seq_editing", 32'(editing), 1);
    checkTime("seq_capture", 12, 34, 56);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkTime("seq_up2", 14, 34, 56);
    applyStimulus(1, 0, 0);
    checkOutput("seq_field_m", 32'(field), 2);
    applyStimulus(0, 0, 1);
    checkTime("seq_down", 14, 33, 56);
    applyStimulus(1, 0, 0);
    checkOutput("seq_field_s", 32'(field), 3);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    checkOutput("seq_load", 32'(load), 1);
    checkOutput("seq_commit_field", 32'(field), 0);
    checkTime("seq_commit", 14, 33, 57);
    tick(1);
    checkOutput("seq_load_off", 32'(load), 0);
    checkOutput("seq_load_cnt", 32'(load_cnt), 1);

    // Wraps from 23:00:59
    cur_hour = 5'd23; cur_min = 6'd0; cur_sec = 6'd59;
    applyStimulus(1, 0, 0);
    checkTime("wrap_capture", 23, 0, 59);
    applyStimulus(0, 1, 0);
    checkTime("wrap_hour", 0, 0, 59);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    checkTime("wrap_min", 0, 59, 59);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkTime("wrap_sec", 0, 59, 0);
    applyStimulus(1, 0, 0);
    checkOutput("wrap_load", 32'(load), 1);
    checkTime("wrap_commit", 0, 59, 0);
    tick(1);
    checkOutput("wrap_load_cnt", 32'(load_cnt), 2);

    // Timeout: 20 idle cycles after the last pulse
    cur_hour = 5'd5; cur_min = 6'd10; cur_sec = 6'd20;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("to_up", 32'(set_hour), 6);
    tick(19);
    checkOutput("to_before_field", 32'(field), 1);
    tick(1);
    checkOutput("to_after_field", 32'(field), 0);
    checkOutput("to_after_editing", 32'(editing), 0);
    checkOutput("to_load_cnt", 32'(load_cnt), 2);

    // UP on the terminal cycle keeps editing
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    tick(19);
    checkOutput("tterm_still_edit", 32'(editing), 1);
    applyStimulus(0, 1, 0);
    checkOutput("tterm_field", 32'(field), 1);
    checkOutput("tterm_hour", 32'(set_hour), 7);
    tick(19);
    checkOutput("tterm_restart", 32'(field), 1);
    tick(1);
    checkOutput("tterm_exit", 32'(field), 0);
    checkOutput("tterm_load_cnt", 32'(load_cnt), 2);

    // Simultaneous pulses and hour underflow
    cur_hour = 5'd0; cur_min = 6'd30; cur_sec = 6'd30;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    checkTime("sim_hour_under", 23, 30, 30);
    applyStimulus(1, 1, 0);
    checkOutput("sim_modeup_field", 32'(field), 2);
    checkTime("sim_modeup", 23, 30, 30);
    applyStimulus(0, 1, 1);
    checkOutput("sim_updown_field", 32'(field), 2);
    checkTime("sim_updown", 23, 30, 30);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("sim_load", 32'(load), 1);
    checkTime("sim_commit", 23, 30, 30);
    tick(1);
    checkOutput("sim_load_cnt", 32'(load_cnt), 3);

    // Blink in EDIT_MIN, half-period 4
    cur_hour = 5'd8; cur_min = 6'd15; cur_sec = 6'd45;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("blk_entry", 32'(blink), 1);
    tick(3);
    checkOutput("blk_e3", 32'(blink), 1);
    tick(1);
    checkOutput("blk_e4", 32'(blink), 0);
    tick(3);
    checkOutput("blk_e7", 32'(blink), 0);
    tick(1);
    checkOutput("blk_e8", 32'(blink), 1);
    tick(4);
    checkOutput("blk_e12", 32'(blink), 0);
    applyStimulus(0, 1, 0);
    checkOutput("blk_up_force", 32'(blink), 1);
    checkOutput("blk_up_min", 32'(set_min), 16);
    tick(3);
    checkOutput("blk_up3", 32'(blink), 1);
    tick(1);
    checkOutput("blk_up4", 32'(blink), 0);

    // Reset mid-edit in EDIT_MIN
    rst_n = 1'b0;
    #2;
    checkOutput("mrst_field", 32'(field), 0);
    checkOutput("mrst_editing", 32'(editing), 0);
    checkOutput("mrst_load", 32'(load), 0);
    checkOutput("mrst_blink", 32'(blink), 1);
    checkTime("mrst", 0, 0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checkOutput("mrst_load_cnt", 32'(load_cnt), 3);
    applyStimulus(0, 1, 0);
    checkOutput("run_up_ignored", 32'(set_hour), 0);
    checkOutput("run_field", 32'(field), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
